// File: rtl/systolic_feeder_if.sv
// Load/start/status and skewed lane bundle between the matrix buffer side (master)
// and the systolic feeder (slave).
interface systolic_feeder_if #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 8
) ();
  localparam int unsigned RowW = (N > 1) ? $clog2(N) : 1;

  logic              load_valid;
  logic              load_ready;
  logic              load_sel;
  logic [RowW-1:0]   load_row;
  logic [N*DW-1:0]   load_data;
  logic              start;
  logic              busy;
  logic              done;
  logic              array_clr;
  logic [N*DW-1:0]   a_out;
  logic [N*DW-1:0]   b_out;

  modport master (
    output load_valid, load_sel, load_row, load_data, start,
    input  load_ready, busy, done, array_clr, a_out, b_out
  );

  modport slave (
    input  load_valid, load_sel, load_row, load_data, start,
    output load_ready, busy, done, array_clr, a_out, b_out
  );
endinterface

// File: rtl/systolic_feeder.sv
// Stores NxN matrices A and B and streams them to a PE array as diagonally skewed
// lane wavefronts: clear, 2N-1 feed beats, drain, then a one-cycle done pulse.
module systolic_feeder #(
  parameter int unsigned N     = 3,
  parameter int unsigned DW    = 8,
  parameter int unsigned DRAIN = 10
) (
  input  logic              clk,
  input  logic              rst,
  systolic_feeder_if.slave  feed_io
);
  localparam int unsigned CntMax = (2 * N > DRAIN) ? 2 * N : DRAIN;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StDrain,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              feed_en;

  logic [DW-1:0]     a_mem_q [N][N];
  logic [DW-1:0]     b_mem_q [N][N];

  logic [N*DW-1:0]   a_beat, b_beat;
  logic [N*DW-1:0]   a_out_q, a_out_d;
  logic [N*DW-1:0]   b_out_q, b_out_d;
  logic              clr_q, clr_d;
  logic              done_q, done_d;
  logic              load_fire;

  assign load_fire = feed_io.load_valid && (state_q == StIdle);

  // Row storage; rows outside 0..N-1 are accepted by the handshake but dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_mem_q[r][c] <= '0;
          b_mem_q[r][c] <= '0;
        end
      end
    end else if (load_fire) begin
      for (int r = 0; r < N; r++) begin
        if (int'(feed_io.load_row) == r) begin
          for (int c = 0; c < N; c++) begin
            if (feed_io.load_sel) begin
              b_mem_q[r][c] <= feed_io.load_data[c*DW +: DW];
            end else begin
              a_mem_q[r][c] <= feed_io.load_data[c*DW +: DW];
            end
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    feed_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (feed_io.start) begin
          state_d = StClear;
        end
      end
      StClear: begin
        state_d = StFeed;
        cnt_d   = '0;
        feed_en = 1'b1;
      end
      StFeed: begin
        if (cnt_q == CntW'(2 * N - 2)) begin
          state_d = (DRAIN == 0) ? StDone : StDrain;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          feed_en = 1'b1;
        end
      end
      StDrain: begin
        if (cnt_q == CntW'(DRAIN - 1)) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Beat t = cnt_d: lane i carries A[i][k] and lane j carries B[r][j] where the
  // lane index plus the inner index equals t.
  always_comb begin
    a_beat = '0;
    b_beat = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (int'(cnt_d) == i + k) begin
          a_beat[i*DW +: DW] = a_mem_q[i][k];
          b_beat[i*DW +: DW] = b_mem_q[k][i];
        end
      end
    end
  end

  always_comb begin
    a_out_d = feed_en ? a_beat : '0;
    b_out_d = feed_en ? b_beat : '0;
    clr_d   = (state_d == StClear);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_out_q <= '0;
      b_out_q <= '0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_out_q <= a_out_d;
      b_out_q <= b_out_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
    end
  end

  assign feed_io.load_ready = (state_q == StIdle);
  assign feed_io.busy       = (state_q != StIdle);
  assign feed_io.done       = done_q;
  assign feed_io.array_clr  = clr_q;
  assign feed_io.a_out      = a_out_q;
  assign feed_io.b_out      = b_out_q;

  a_done_in_done_state: assert property (@(posedge clk) disable iff (rst)
    done_q |-> (state_q == StDone));
  a_clr_lanes_quiet: assert property (@(posedge clk) disable iff (rst)
    clr_q |-> (a_out_q == '0 && b_out_q == '0));

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: beat stream scoreboard plus control timing table.
module tb_systolic_feeder;
  localparam int unsigned N     = 3;
  localparam int unsigned DW    = 8;
  localparam int unsigned DRAIN = 10;
  localparam int          NB    = 2 * N - 1;

  typedef struct {
    logic [N*DW-1:0] a;
    logic [N*DW-1:0] b;
  } beat_t;

  typedef struct {
    int   off;
    logic clr;
    logic done;
    logic busy;
    logic ready;
  } tim_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   done_cnt;
  int   feed_left;

  beat_t         exp_q[$];
  beat_t         tab1[NB];
  tim_t          tim[7];
  logic [DW-1:0] am[N][N];
  logic [DW-1:0] bm[N][N];

  systolic_feeder_if #(.N(N), .DW(DW)) feed_if ();

  systolic_feeder #(.N(N), .DW(DW), .DRAIN(DRAIN)) dut (
    .clk     (clk),
    .rst     (rst),
    .feed_io (feed_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*DW-1:0] pack(input int l0, input int l1, input int l2);
    return {DW'(l2), DW'(l1), DW'(l0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_set(input logic sel, input int row, input logic [N*DW-1:0] d);
    if (row < N) begin
      for (int j = 0; j < N; j++) begin
        if (sel) bm[row][j] = d[j*DW +: DW];
        else     am[row][j] = d[j*DW +: DW];
      end
    end
  endtask

  task automatic load(input logic sel, input int row, input logic [N*DW-1:0] d);
    feed_if.load_valid = 1'b1;
    feed_if.load_sel   = sel;
    feed_if.load_row   = 2'(row);
    feed_if.load_data  = d;
    step();
    feed_if.load_valid = 1'b0;
    model_set(sel, row, d);
  endtask

  task automatic push_model();
    for (int t = 0; t < NB; t++) begin
      beat_t bt;
      bt.a = '0;
      bt.b = '0;
      for (int i = 0; i < N; i++) begin
        if (t - i >= 0 && t - i < N) bt.a[i*DW +: DW] = am[i][t-i];
        if (t - i >= 0 && t - i < N) bt.b[i*DW +: DW] = bm[t-i][i];
      end
      exp_q.push_back(bt);
    end
  endtask

  task automatic push_tab1();
    for (int t = 0; t < NB; t++) exp_q.push_back(tab1[t]);
  endtask

  task automatic start_run();
    feed_if.start = 1'b1;
    step();
    feed_if.start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (feed_if.busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ends"}, 64'(feed_if.busy), 64'd0);
    check({name, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
    step();
  endtask

  // Scoreboard: the NB cycles after an array_clr cycle carry beats; all others are zero.
  always @(negedge clk) begin
    if (rst) begin
      feed_left = 0;
      exp_q.delete();
    end else begin
      if (feed_if.done) done_cnt++;
      if (feed_left > 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow: got beat a=%0h b=%0h, expected none queued",
                   feed_if.a_out, feed_if.b_out);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_a", 64'(feed_if.a_out), 64'(e.a));
          check("beat_b", 64'(feed_if.b_out), 64'(e.b));
        end
        feed_left--;
      end else begin
        check("quiet_a", 64'(feed_if.a_out), 64'd0);
        check("quiet_b", 64'(feed_if.b_out), 64'd0);
      end
      if (feed_if.array_clr) feed_left = NB;
    end
  end

  initial begin
    int cur;
    int d0;
    checks    = 0;
    failures  = 0;
    done_cnt  = 0;
    feed_left = 0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        am[r][c] = '0;
        bm[r][c] = '0;
      end
    end

    tab1[0] = '{pack(1, 0, 0), pack(9, 0, 0)};
    tab1[1] = '{pack(2, 4, 0), pack(8, 6, 0)};
    tab1[2] = '{pack(3, 5, 7), pack(7, 5, 3)};
    tab1[3] = '{pack(0, 6, 8), pack(0, 4, 2)};
    tab1[4] = '{pack(0, 0, 9), pack(0, 0, 1)};

    // Offsets are cycles after the edge that sampled start.
    tim[0] = '{1,  1'b1, 1'b0, 1'b1, 1'b0};
    tim[1] = '{2,  1'b0, 1'b0, 1'b1, 1'b0};
    tim[2] = '{7,  1'b0, 1'b0, 1'b1, 1'b0};
    tim[3] = '{16, 1'b0, 1'b0, 1'b1, 1'b0};
    tim[4] = '{17, 1'b0, 1'b1, 1'b1, 1'b0};
    tim[5] = '{18, 1'b0, 1'b0, 1'b0, 1'b1};
    tim[6] = '{19, 1'b0, 1'b0, 1'b0, 1'b1};

    rst                = 1'b1;
    feed_if.load_valid = 1'b0;
    feed_if.load_sel   = 1'b0;
    feed_if.load_row   = '0;
    feed_if.load_data  = '0;
    feed_if.start      = 1'b0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(feed_if.busy), 64'd0);
    check("rst_done", 64'(feed_if.done), 64'd0);
    check("rst_clr", 64'(feed_if.array_clr), 64'd0);
    check("rst_ready", 64'(feed_if.load_ready), 64'd1);
    step();

    // Reference matrices, then control timing walked alongside the beat scoreboard.
    load(1'b0, 0, pack(1, 2, 3));
    load(1'b0, 1, pack(4, 5, 6));
    load(1'b0, 2, pack(7, 8, 9));
    load(1'b1, 0, pack(9, 6, 3));
    load(1'b1, 1, pack(8, 5, 2));
    load(1'b1, 2, pack(7, 4, 1));
    push_tab1();
    start_run();
    cur = 1;
    for (int i = 0; i < 7; i++) begin
      while (cur < tim[i].off) begin
        @(posedge clk);
        cur++;
      end
      @(negedge clk);
      check($sformatf("clr_k%0d", tim[i].off), 64'(feed_if.array_clr), 64'(tim[i].clr));
      check($sformatf("done_k%0d", tim[i].off), 64'(feed_if.done), 64'(tim[i].done));
      check($sformatf("busy_k%0d", tim[i].off), 64'(feed_if.busy), 64'(tim[i].busy));
      check($sformatf("ready_k%0d", tim[i].off), 64'(feed_if.load_ready), 64'(tim[i].ready));
    end
    step();
    check("done_count_run1", 64'(done_cnt), 64'd1);

    // Start and a load attempt during FEED are both ignored.
    push_tab1();
    start_run();
    step();
    step();
    feed_if.start      = 1'b1;
    feed_if.load_valid = 1'b1;
    feed_if.load_sel   = 1'b0;
    feed_if.load_row   = '0;
    feed_if.load_data  = pack(5, 5, 5);
    @(negedge clk);
    check("ready_in_feed", 64'(feed_if.load_ready), 64'd0);
    step();
    feed_if.start      = 1'b0;
    feed_if.load_valid = 1'b0;
    wait_idle("run_busy_poke");
    push_tab1();
    start_run();
    wait_idle("run_replay");

    // Extreme negative values pass through unchanged.
    for (int r = 0; r < N; r++) load(1'b0, r, pack(-128, -128, -128));
    for (int r = 0; r < N; r++) load(1'b1, r, pack(-1, -1, -1));
    push_model();
    start_run();
    wait_idle("run_neg");

    // Reset during beat 2 aborts the run and clears storage.
    push_model();
    start_run();
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(feed_if.busy), 64'd0);
    check("abort_ready", 64'(feed_if.load_ready), 64'd1);
    check("abort_done", 64'(feed_if.done), 64'd0);
    check("abort_a", 64'(feed_if.a_out), 64'd0);
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'(d0));
    step();
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        am[r][c] = '0;
        bm[r][c] = '0;
      end
    end
    push_model();
    start_run();
    wait_idle("run_after_abort");

    // Out-of-range row is dropped; a load coinciding with start is used by the run.
    load(1'b1, 3, pack(55, 66, 77));
    feed_if.load_valid = 1'b1;
    feed_if.load_sel   = 1'b0;
    feed_if.load_row   = '0;
    feed_if.load_data  = pack(10, 20, 30);
    feed_if.start      = 1'b1;
    model_set(1'b0, 0, pack(10, 20, 30));
    push_model();
    step();
    feed_if.load_valid = 1'b0;
    feed_if.start      = 1'b0;
    wait_idle("run_load_start");

    check("done_count_total", 64'(done_cnt), 64'd6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
